// File: rtl/bram_burst_master.sv
// Command-driven initiator for the BRAM controller request port: write stream to per-word triggers,
// reads split into FIFO-sized bursts behind an FWFT FIFO. Optional check logic: BRAM_MASTER_ERRCHK_EN.
module bram_burst_master #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_BURST  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic              mem_trigger,
   output logic              mem_read_or_write,
   output logic [ADDR_W-1:0] mem_start_address,
   output logic [7:0]        mem_no_of_bytes,
   output logic [DATA_W-1:0] mem_input_data,
   input  logic [DATA_W-1:0] mem_output_data,
   input  logic              mem_output_ready,
   input  logic              mem_read_complete
`ifdef BRAM_MASTER_ERRCHK_EN
   ,
   output logic              err
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAPTURE, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [CW-1:0]       chunk_q, chunk_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                trig_q, trig_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   maddr_q, maddr_d;
   logic [7:0]          mlen_q, mlen_d;
   logic [DATA_W-1:0]   mdata_q, mdata_d;

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wptr_q, rptr_q;
   logic [CW-1:0]       count_q;

   logic                window, last_cap, push, pop;
   logic [CW-1:0]       issue_chunk;

   // Burst size limited by remaining words, the burst cap and current FIFO free space.
   function automatic logic [CW-1:0] calc_chunk(input logic [LEN_W-1:0] rem, input logic [CW-1:0] used);
      logic [31:0] c;
      logic [31:0] free;
      c    = 32'(rem);
      free = 32'(FIFO_DEPTH) - 32'(used);
      if (c > 32'(MAX_BURST)) c = 32'(MAX_BURST);
      if (c > free)           c = free;
      return CW'(c);
   endfunction

   // The trigger cycle itself is not part of the capture window; words arrive on the following cycles.
   assign window      = (state_q == RD_CAPTURE) && !trig_q;
   assign last_cap    = window && (cnt_q == chunk_q - CW'(1));
   assign push        = window;
   assign pop         = (count_q != '0) && rd_ready;
   assign issue_chunk = calc_chunk(rem_q, count_q);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      chunk_d   = chunk_q;
      cnt_d     = cnt_q;
      trig_d    = 1'b0;
      rw_d      = rw_q;
      maddr_d   = maddr_q;
      mlen_d    = mlen_q;
      mdata_d   = mdata_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      done      = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d = cmd_addr;
               rem_d  = cmd_len;
               if (cmd_len == '0)  state_d = DONE;
               else if (cmd_write) state_d = WRITE;
               else                state_d = RD_ISSUE;
            end
         end
         WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               trig_d  = 1'b1;
               rw_d    = 1'b0;
               maddr_d = addr_q;
               mdata_d = wr_data;
               addr_d  = addr_q + ADDR_W'(1);
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = DONE;
            end
         end
         RD_ISSUE: begin
            if (issue_chunk != '0) begin
               trig_d  = 1'b1;
               rw_d    = 1'b1;
               maddr_d = addr_q;
               mlen_d  = 8'(issue_chunk);
               chunk_d = issue_chunk;
               cnt_d   = '0;
               state_d = RD_CAPTURE;
            end
         end
         RD_CAPTURE: begin
            if (window) begin
               cnt_d = cnt_q + CW'(1);
               if (last_cap) begin
                  addr_d  = addr_q + ADDR_W'(chunk_q);
                  rem_d   = rem_q - LEN_W'(chunk_q);
                  state_d = (rem_q == LEN_W'(chunk_q)) ? DONE : RD_ISSUE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         chunk_q <= '0;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         rw_q    <= 1'b0;
         maddr_q <= '0;
         mlen_q  <= '0;
         mdata_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         chunk_q <= chunk_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         rw_q    <= rw_d;
         maddr_q <= maddr_d;
         mlen_q  <= mlen_d;
         mdata_q <= mdata_d;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr_q] <= mem_output_data;
   end

   assign rd_data           = fifo_mem[rptr_q];
   assign rd_valid          = (count_q != '0);
   assign mem_trigger       = trig_q;
   assign mem_read_or_write = rw_q;
   assign mem_start_address = maddr_q;
   assign mem_no_of_bytes   = mlen_q;
   assign mem_input_data    = mdata_q;

`ifdef BRAM_MASTER_ERRCHK_EN
   logic err_q;

   // Sticky: controller dropped its qualifier mid-window or claimed completion early.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (window && (!mem_output_ready || (mem_read_complete && !last_cap))) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_ctrl_flags;
   assign unused_ctrl_flags = mem_output_ready ^ mem_read_complete;
`endif

endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a behavioural BRAM controller model and trigger/readout logs.
module tb_bram_burst_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        busy;
   logic        done;
   logic        mem_trigger;
   logic        mem_read_or_write;
   logic [7:0]  mem_start_address;
   logic [7:0]  mem_no_of_bytes;
   logic [31:0] mem_input_data;
   logic [31:0] mem_output_data;
   logic        mem_output_ready;
   logic        mem_read_complete;
`ifdef BRAM_MASTER_ERRCHK_EN
   logic        err;
`endif

   bram_burst_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done),
      .mem_trigger(mem_trigger), .mem_read_or_write(mem_read_or_write),
      .mem_start_address(mem_start_address), .mem_no_of_bytes(mem_no_of_bytes),
      .mem_input_data(mem_input_data), .mem_output_data(mem_output_data),
      .mem_output_ready(mem_output_ready), .mem_read_complete(mem_read_complete)
`ifdef BRAM_MASTER_ERRCHK_EN
      , .err(err)
`endif
   );

   typedef struct {
      logic        rw;
      logic [7:0]  addr;
      logic [7:0]  len;
      logic [31:0] data;
      int          cyc;
   } trig_t;

   trig_t       tq[$];
   logic [31:0] rxq[$];
   logic [31:0] mmem [256];
   logic [7:0]  baddr;
   int          blen;
   int          cyc;
   int          done_cnt;
   int          done_cyc;
   int          n_tests;
   int          n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Controller model plus monitors, all evaluated on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         blen = 0;
      end else begin
         if (mem_trigger) tq.push_back('{mem_read_or_write, mem_start_address, mem_no_of_bytes, mem_input_data, cyc});
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_valid && rd_ready) rxq.push_back(rd_data);
         if (blen > 0) begin
            mem_output_data = mmem[baddr];
            baddr = baddr + 8'd1;
            blen--;
         end
         if (mem_trigger && mem_read_or_write) begin
            baddr = mem_start_address;
            blen  = int'(mem_no_of_bytes);
         end
         if (mem_trigger && !mem_read_or_write) mmem[mem_start_address] = mem_input_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
      int k;
      k = 0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      while (!cmd_ready && k < 100) begin
         tick();
         k++;
      end
      check("cmd_handshake", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int start, input int budget);
      int k;
      k = 0;
      while (done_cnt == start && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, done_cnt - start, 32'd1);
      tick();
   endtask

   task automatic check_rx(input string tag, input logic [31:0] exp[$]);
      check({tag, "_count"}, rxq.size(), exp.size());
      for (int i = 0; i < exp.size() && i < rxq.size(); i++)
         check($sformatf("%s_word%0d", tag, i), rxq[i], exp[i]);
   endtask

   initial begin
      logic [31:0] exp[$];
      logic        acc;
      int          idx;
      int          k;
      int          ds;
      int          sum;

      n_tests = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cyc = 0; blen = 0; baddr = '0;
      for (int i = 0; i < 256; i++) mmem[i] = 32'hD000_0000 | i;
      reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      wr_data = 0; wr_valid = 0; rd_ready = 0; mem_output_data = 0;
      mem_output_ready = 1'b1; mem_read_complete = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_wr_ready", {31'd0, wr_ready}, 0);
      check("rst_rd_valid", {31'd0, rd_valid}, 0);
      check("rst_trigger", {31'd0, mem_trigger}, 0);
      check("rst_rw", {31'd0, mem_read_or_write}, 0);
      check("rst_addr", {24'd0, mem_start_address}, 0);
      check("rst_len", {24'd0, mem_no_of_bytes}, 0);
      check("rst_wdata", mem_input_data, 0);
      reset = 1'b0;
      tick();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
`ifdef BRAM_MASTER_ERRCHK_EN
      check("rst_err", {31'd0, err}, 0);
`endif

      // Write 4 words at 0x10
      tq.delete();
      ds = done_cnt;
      wr_valid = 1'b1;
      wr_data  = 32'hA;
      send_cmd(1'b1, 8'h10, 8'd4);
      idx = 0; k = 0;
      while (idx < 4 && k < 50) begin
         @(negedge clk);
         acc = wr_ready;
         tick();
         if (acc) begin
            idx++;
            wr_data = 32'hA + idx;
         end
         k++;
      end
      wr_valid = 1'b0;
      wait_done("wr_done", ds, 20);
      check("wr_trig_count", tq.size(), 4);
      for (int i = 0; i < tq.size(); i++) begin
         check($sformatf("wr_rw%0d", i), {31'd0, tq[i].rw}, 0);
         check($sformatf("wr_addr%0d", i), {24'd0, tq[i].addr}, 32'h10 + i);
         check($sformatf("wr_data%0d", i), tq[i].data, 32'hA + i);
         check($sformatf("wr_cyc%0d", i), tq[i].cyc - tq[0].cyc, i);
      end
      check("wr_busy_after", {31'd0, busy}, 0);
      check("wr_cmd_ready_after", {31'd0, cmd_ready}, 1);

      // Short read of 5 at 0x10, consumer always ready
      tq.delete(); rxq.delete();
      rd_ready = 1'b1;
      ds = done_cnt;
      send_cmd(1'b0, 8'h10, 8'd5);
      wait_done("rd5_done", ds, 40);
      repeat (4) tick();
      check("rd5_trig_count", tq.size(), 1);
      if (tq.size() > 0) begin
         check("rd5_rw", {31'd0, tq[0].rw}, 1);
         check("rd5_addr", {24'd0, tq[0].addr}, 32'h10);
         check("rd5_len", {24'd0, tq[0].len}, 5);
         check("rd5_done_latency", done_cyc - tq[0].cyc, 6);
      end
      exp = {32'hA, 32'hB, 32'hC, 32'hD, 32'hD000_0014};
      check_rx("rd5", exp);

      // Backpressure: 20 words with consumer stalled
      tq.delete(); rxq.delete();
      rd_ready = 1'b0;
      for (int i = 0; i < 20; i++) mmem[i] = 32'hD000_0000 | i;
      ds = done_cnt;
      send_cmd(1'b0, 8'h00, 8'd20);
      repeat (30) tick();
      check("bp_stall_trigs", tq.size(), 1);
      if (tq.size() > 0) check("bp_first_len", {24'd0, tq[0].len}, 8);
      check("bp_rd_valid", {31'd0, rd_valid}, 1);
      check("bp_busy", {31'd0, busy}, 1);
      rd_ready = 1'b1;
      wait_done("bp_done", ds, 300);
      repeat (20) tick();
      sum = 0;
      for (int i = 1; i < tq.size(); i++) begin
         sum += int'(tq[i].len);
         check($sformatf("bp_contig%0d", i), {24'd0, tq[i].addr}, tq[i-1].addr + tq[i-1].len);
         check($sformatf("bp_len_le8_%0d", i), {31'd0, (tq[i].len <= 8'd8)}, 1);
      end
      check("bp_rest_words", sum, 12);
      exp.delete();
      for (int i = 0; i < 20; i++) exp.push_back(32'hD000_0000 | i);
      check_rx("bp", exp);

      // Address wrap: write 3 at 0xFE, read back
      tq.delete(); rxq.delete();
      ds = done_cnt;
      wr_valid = 1'b1;
      wr_data  = 32'h111;
      send_cmd(1'b1, 8'hFE, 8'd3);
      idx = 0; k = 0;
      while (idx < 3 && k < 50) begin
         @(negedge clk);
         acc = wr_ready;
         tick();
         if (acc) begin
            idx++;
            wr_data = 32'h111 * (idx + 1);
         end
         k++;
      end
      wr_valid = 1'b0;
      wait_done("wrap_wr_done", ds, 20);
      check("wrap_wr_trigs", tq.size(), 3);
      if (tq.size() == 3) begin
         check("wrap_addr0", {24'd0, tq[0].addr}, 32'hFE);
         check("wrap_addr1", {24'd0, tq[1].addr}, 32'hFF);
         check("wrap_addr2", {24'd0, tq[2].addr}, 32'h00);
      end
      tq.delete();
      ds = done_cnt;
      send_cmd(1'b0, 8'hFE, 8'd3);
      wait_done("wrap_rd_done", ds, 40);
      repeat (4) tick();
      check("wrap_rd_trigs", tq.size(), 1);
      if (tq.size() > 0) check("wrap_rd_len", {24'd0, tq[0].len}, 3);
      exp = {32'h111, 32'h222, 32'h333};
      check_rx("wrap_rd", exp);

      // Zero length in both directions
      tq.delete();
      send_cmd(1'b1, 8'h40, 8'd0);
      check("zl_wr_done", {31'd0, done}, 1);
      tick();
      check("zl_wr_done_gone", {31'd0, done}, 0);
      check("zl_wr_cmd_ready", {31'd0, cmd_ready}, 1);
      send_cmd(1'b0, 8'h40, 8'd0);
      check("zl_rd_done", {31'd0, done}, 1);
      tick();
      check("zl_rd_cmd_ready", {31'd0, cmd_ready}, 1);
      check("zl_no_trigs", tq.size(), 0);

      // New command accepted while FIFO still holds earlier read data
      rxq.delete();
      rd_ready = 1'b0;
      ds = done_cnt;
      send_cmd(1'b0, 8'h50, 8'd3);
      wait_done("carry_a_done", ds, 40);
      ds = done_cnt;
      send_cmd(1'b0, 8'h60, 8'd2);
      wait_done("carry_b_done", ds, 40);
      check("carry_held", rxq.size(), 0);
      rd_ready = 1'b1;
      repeat (10) tick();
      exp = {32'hD000_0050, 32'hD000_0051, 32'hD000_0052, 32'hD000_0060, 32'hD000_0061};
      check_rx("carry", exp);

      // Reset during a capture window
      tq.delete(); rxq.delete();
      rd_ready = 1'b0;
      send_cmd(1'b0, 8'h20, 8'd6);
      k = 0;
      while (tq.size() == 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("mr_trigger_seen", tq.size(), 1);
      repeat (3) @(negedge clk);
      check("mr_pre_rd_valid", {31'd0, rd_valid}, 1);
      ds = done_cnt;
      reset = 1'b1;
      #1;
      check("mr_busy", {31'd0, busy}, 0);
      check("mr_rd_valid", {31'd0, rd_valid}, 0);
      check("mr_trigger", {31'd0, mem_trigger}, 0);
      check("mr_done", {31'd0, done}, 0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) tick();
      check("mr_no_done", done_cnt - ds, 0);
      check("mr_idle", {31'd0, cmd_ready}, 1);
      rxq.delete();
      rd_ready = 1'b1;
      ds = done_cnt;
      send_cmd(1'b0, 8'h30, 8'd2);
      wait_done("mr_next_done", ds, 40);
      repeat (4) tick();
      exp = {32'hD000_0030, 32'hD000_0031};
      check_rx("mr_next", exp);

`ifdef BRAM_MASTER_ERRCHK_EN
      check("err_clean", {31'd0, err}, 0);
      mem_output_ready = 1'b0;
      ds = done_cnt;
      send_cmd(1'b0, 8'h70, 8'd2);
      wait_done("err_rd_done", ds, 40);
      mem_output_ready = 1'b1;
      check("err_set", {31'd0, err}, 1);
      repeat (5) tick();
      check("err_sticky", {31'd0, err}, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
